// File: rtl/dpy_point_ctrl_pkg.sv
// dpy_point_ctrl_pkg
//   Shared definitions for the PDP-1 Type 30 display point controller:
//   default coordinate width, settle-counter width and controller FSM states.
package dpy_point_ctrl_pkg;

    // Screen coordinate width (10-bit signed PDP-1 coordinate -> 10-bit unsigned).
    localparam int unsigned DPY_COORD_W  = 10;

    // Settle counter width; holds SETTLE_CYCLES-1 for SETTLE_CYCLES up to 4095.
    localparam int unsigned DPY_SETTLE_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_SETTLE = 2'd2
    } dpy_state_e;

endpackage

// File: rtl/dpy_cmd_fifo.sv
// dpy_cmd_fifo
//   Small synchronous command FIFO with show-ahead read data and a
//   registered full flag.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//     push      : write wdata (ignored while full)
//     pop       : advance read pointer (ignored while empty)
//     wdata     : write data
//     rdata     : head entry, valid whenever empty is low
//     full      : registered, occupancy == depth
//     empty     : occupancy == 0
module dpy_cmd_fifo
    import dpy_point_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH   = 21,
    parameter int unsigned FIFO_AW = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned       LP_DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]  LP_FULL_CNT = (FIFO_AW+1)'(LP_DEPTH);
    localparam logic [FIFO_AW:0]  LP_ONE      = (FIFO_AW+1)'(1);

    logic [WIDTH-1:0]   r_mem [LP_DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_full;

    logic [FIFO_AW:0]   w_count_nxt;
    logic               w_do_push;
    logic               w_do_pop;
    logic               w_empty;

    assign w_empty   = (r_count == '0);
    assign w_do_push = push && !r_full;
    assign w_do_pop  = pop && !w_empty;

    // Simultaneous push and pop leave occupancy unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + LP_ONE;
            2'b01:   w_count_nxt = r_count - LP_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == LP_FULL_CNT);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    assign rdata = r_mem[r_rptr];
    assign full  = r_full;
    assign empty = w_empty;

endmodule

// File: rtl/dpy_point_ctrl.sv
// dpy_point_ctrl
//   CPU-side producer of Type 30 display exposures. Queues dpy IOT commands,
//   converts the signed PDP-1 coordinates to unsigned screen coordinates,
//   emits one-cycle strobes with held x/y, enforces a phosphor settle time
//   and optionally returns a completion pulse.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     dpy_req      : one-cycle command pulse
//     dpy_wait     : command wants dpy_done on completion (sampled with dpy_req)
//     ac, io       : X in ac[17:8], Y in io[17:8] (signed)
//     dpy_ready    : FIFO not full; req accepted only while high
//     dpy_done     : one-cycle completion pulse for wait commands
//     dpy_idle     : FIFO empty and controller idle
//     dpy_overflow : sticky, a req arrived while dpy_ready was low
//     strobe, x, y : exposure pulse and screen coordinates to the raster converter
module dpy_point_ctrl
    import dpy_point_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2500,
    parameter int unsigned FIFO_AW       = 2,
    parameter int unsigned COORD_W       = DPY_COORD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dpy_req,
    input  logic               dpy_wait,
    input  logic [17:0]        ac,
    input  logic [17:0]        io,
    output logic               dpy_ready,
    output logic               dpy_done,
    output logic               dpy_idle,
    output logic               dpy_overflow,
    output logic               strobe,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y
);

    localparam int unsigned              LP_ENTRY_W     = 2 * COORD_W + 1;
    localparam logic [DPY_SETTLE_W-1:0]  LP_SETTLE_LOAD = DPY_SETTLE_W'(SETTLE_CYCLES - 1);

    dpy_state_e                r_state;
    dpy_state_e                w_state_nxt;
    logic [DPY_SETTLE_W-1:0]   r_cnt;
    logic [COORD_W-1:0]        r_x;
    logic [COORD_W-1:0]        r_y;
    logic                      r_wait;
    logic                      r_done;
    logic                      r_overflow;

    logic [COORD_W-1:0]        w_ac_c;
    logic [COORD_W-1:0]        w_io_c;
    logic [COORD_W-1:0]        w_x_cvt;
    logic [COORD_W-1:0]        w_y_cvt;
    logic [LP_ENTRY_W-1:0]     w_wdata;
    logic [LP_ENTRY_W-1:0]     w_rdata;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_unused;

    assign w_ac_c = ac[17 -: COORD_W];
    assign w_io_c = io[17 -: COORD_W];

    // Sign-flip maps signed X onto 0..max. Y additionally inverts the
    // magnitude because screen rows grow downward while PDP-1 Y grows upward.
    assign w_x_cvt = {~w_ac_c[COORD_W-1], w_ac_c[COORD_W-2:0]};
    assign w_y_cvt = {w_io_c[COORD_W-1], ~w_io_c[COORD_W-2:0]};
    assign w_wdata = {dpy_wait, w_x_cvt, w_y_cvt};

    assign w_unused = &{1'b0, ac[17-COORD_W:0], io[17-COORD_W:0]};

    assign dpy_ready = !w_full;
    assign w_push    = dpy_req && dpy_ready;

    dpy_cmd_fifo #(
        .WIDTH   (LP_ENTRY_W),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_wdata),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_STROBE;
                end
            end
            ST_STROBE: begin
                w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_wait     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;

            if (w_pop) begin
                r_wait <= w_rdata[LP_ENTRY_W-1];
                r_x    <= w_rdata[2*COORD_W-1 -: COORD_W];
                r_y    <= w_rdata[COORD_W-1:0];
            end

            if (r_state == ST_STROBE) begin
                r_cnt <= LP_SETTLE_LOAD;
            end else if (r_state == ST_SETTLE) begin
                if (r_cnt == '0) begin
                    r_done <= r_wait;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end

            if (dpy_req && !dpy_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign strobe       = (r_state == ST_STROBE);
    assign x            = r_x;
    assign y            = r_y;
    assign dpy_done     = r_done;
    assign dpy_overflow = r_overflow;
    assign dpy_idle     = w_empty && (r_state == ST_IDLE);

endmodule

// File: tb/tb_dpy_point_ctrl.sv
module tb_dpy_point_ctrl;

    logic        clk;
    logic        rst;
    logic        dpy_req;
    logic        dpy_wait;
    logic [17:0] ac;
    logic [17:0] io;
    logic        dpy_ready;
    logic        dpy_done;
    logic        dpy_idle;
    logic        dpy_overflow;
    logic        strobe;
    logic [9:0]  x;
    logic [9:0]  y;

    dpy_point_ctrl #(
        .SETTLE_CYCLES (8),
        .FIFO_AW       (2),
        .COORD_W       (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .dpy_req      (dpy_req),
        .dpy_wait     (dpy_wait),
        .ac           (ac),
        .io           (io),
        .dpy_ready    (dpy_ready),
        .dpy_done     (dpy_done),
        .dpy_idle     (dpy_idle),
        .dpy_overflow (dpy_overflow),
        .strobe       (strobe),
        .x            (x),
        .y            (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Event log, sampled mid-cycle; cycle index = edge that ends the cycle.
    int unsigned st_cyc [$];
    logic [9:0]  st_x   [$];
    logic [9:0]  st_y   [$];
    int unsigned dn_cyc [$];
    logic        dn_idle[$];
    logic        prev_strobe = 1'b0;
    int unsigned back2back   = 0;

    always @(negedge clk) begin
        if (strobe === 1'b1) begin
            st_cyc.push_back(cyc + 1);
            st_x.push_back(x);
            st_y.push_back(y);
            if (prev_strobe) back2back++;
        end
        if (dpy_done === 1'b1) begin
            dn_cyc.push_back(cyc + 1);
            dn_idle.push_back(dpy_idle);
        end
        prev_strobe = (strobe === 1'b1);
    end

    task automatic clear_log();
        st_cyc.delete(); st_x.delete(); st_y.delete();
        dn_cyc.delete(); dn_idle.delete();
    endtask

    // Called on a negedge; n returns the edge that samples the request.
    task automatic issue(input logic [9:0] xa, input logic [9:0] yi, input logic w,
                         output int unsigned n);
        ac       = {xa, 8'h5A};
        io       = {yi, 8'hC3};
        dpy_wait = w;
        dpy_req  = 1'b1;
        n        = cyc + 1;
        @(negedge clk);
        dpy_req  = 1'b0;
        dpy_wait = 1'b0;
    endtask

    int unsigned n0, n1, n2, n3, n4;
    logic [9:0] bx_a [4];
    logic [9:0] by_i [4];
    int unsigned bx_e [4];
    int unsigned by_e [4];
    int unsigned nb [4];

    initial begin
        rst = 1'b1; dpy_req = 1'b0; dpy_wait = 1'b0; ac = '0; io = '0;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_strobe",   32'(strobe),       0);
        chk("rst_done",     32'(dpy_done),     0);
        chk("rst_ready",    32'(dpy_ready),    1);
        chk("rst_idle",     32'(dpy_idle),     1);
        chk("rst_overflow", 32'(dpy_overflow), 0);
        chk("rst_x",        32'(x),            0);
        chk("rst_y",        32'(y),            0);
        rst = 1'b0;
        @(negedge clk);
        clear_log();

        // Single point at origin, wait=1
        issue(10'h000, 10'h000, 1'b1, n0);
        repeat (20) @(negedge clk);
        chk("org_nstrobe",  32'(st_cyc.size()), 1);
        chk("org_strobe_c", st_cyc[0], n0 + 2);
        chk("org_x",        32'(st_x[0]), 512);
        chk("org_y",        32'(st_y[0]), 511);
        chk("org_ndone",    32'(dn_cyc.size()), 1);
        chk("org_done_c",   dn_cyc[0], n0 + 11);
        chk("org_idle_at_done", 32'(dn_idle[0]), 1);
        chk("org_idle_end", 32'(dpy_idle), 1);
        clear_log();

        // Extremes
        issue(10'h1FF, 10'h200, 1'b0, n1);
        repeat (12) @(negedge clk);
        issue(10'h200, 10'h1FF, 1'b0, n2);
        repeat (12) @(negedge clk);
        chk("ext_nstrobe", 32'(st_cyc.size()), 2);
        chk("ext_max_x",   32'(st_x[0]), 1023);
        chk("ext_max_y",   32'(st_y[0]), 1023);
        chk("ext_min_x",   32'(st_x[1]), 0);
        chk("ext_min_y",   32'(st_y[1]), 0);
        chk("ext_ndone",   32'(dn_cyc.size()), 0);
        clear_log();

        // Back-to-back, wait=0
        bx_a[0] = 10'h001; by_i[0] = 10'h001; bx_e[0] = 513; by_e[0] = 510;
        bx_a[1] = 10'h3FE; by_i[1] = 10'h3FE; bx_e[1] = 510; by_e[1] = 513;
        bx_a[2] = 10'h100; by_i[2] = 10'h100; bx_e[2] = 768; by_e[2] = 255;
        bx_a[3] = 10'h2AA; by_i[3] = 10'h2AA; bx_e[3] = 170; by_e[3] = 853;
        for (int i = 0; i < 4; i++) issue(bx_a[i], by_i[i], 1'b0, nb[i]);
        repeat (45) @(negedge clk);
        chk("b2b_nstrobe", 32'(st_cyc.size()), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b2b_cyc%0d", i), st_cyc[i], nb[0] + 2 + 10 * i);
            chk($sformatf("b2b_x%0d", i),   32'(st_x[i]), bx_e[i]);
            chk($sformatf("b2b_y%0d", i),   32'(st_y[i]), by_e[i]);
        end
        chk("b2b_ndone",    32'(dn_cyc.size()), 0);
        chk("b2b_overflow", 32'(dpy_overflow), 0);
        clear_log();

        // Overflow: one in flight, then five requests
        issue(10'h010, 10'h020, 1'b0, n3);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("ovf_ready%0d", i), 32'(dpy_ready), (i < 4) ? 1 : 0);
            if (i == 4) chk("ovf_flag_before", 32'(dpy_overflow), 0);
            issue(10'(i), 10'(i), 1'b0, n4);
        end
        chk("ovf_flag", 32'(dpy_overflow), 1);
        repeat (60) @(negedge clk);
        chk("ovf_nstrobe", 32'(st_cyc.size()), 5);
        chk("ovf_flag_sticky", 32'(dpy_overflow), 1);
        chk("ovf_ready_end", 32'(dpy_ready), 1);
        clear_log();

        // Reset during SETTLE of a wait=1 command with two queued
        issue(10'h055, 10'h066, 1'b1, n0);
        issue(10'h077, 10'h088, 1'b1, n1);
        issue(10'h099, 10'h0AA, 1'b1, n2);
        repeat (3) @(negedge clk);
        chk("rsm_strobe_seen", 32'(st_cyc.size()), 1);
        clear_log();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("rsm_nstrobe",  32'(st_cyc.size()), 0);
        chk("rsm_ndone",    32'(dn_cyc.size()), 0);
        chk("rsm_idle",     32'(dpy_idle), 1);
        chk("rsm_overflow", 32'(dpy_overflow), 0);
        chk("rsm_ready",    32'(dpy_ready), 1);

        chk("no_consecutive_strobes", back2back, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
